// File: rtl/crossyroad_game_ctrl.sv
// Crossy-road game controller: debounced move button, lane scroll FSM,
// lane-type LFSR, saturating score and post-death timeout.
module crossyroad_game_ctrl #(
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter int          SCROLL_STEP = 2,
  parameter int          DEAD_FRAMES = 120,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_btn,
  input  logic       frame_start,
  input  logic       collision,
  output logic [1:0] state,
  output logic [3:0] scroll_offset,
  output logic       lane_shift,
  output logic [1:0] new_lane,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_SCROLL = 2'd2;
  localparam logic [1:0] S_DEAD   = 2'd3;

  logic        sync1, sync2;
  logic        deb_level, deb_prev;
  logic [15:0] deb_cnt;
  logic        press;
  logic        pending;
  logic [15:0] dead_cnt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [3:0]  offset_sum;
  logic        hit;
  logic        wrap;
  logic [1:0]  state_d;

  // Button conditioning: synchronizer then a counter that must see the new
  // level for DEB_CYCLES consecutive cycles before the debounced level flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= 16'd0;
    end else begin
      sync1    <= move_btn;
      sync2    <= sync1;
      deb_prev <= deb_level;
      if (sync2 != deb_level) begin
        if (deb_cnt == DEB_CYCLES - 16'd1) begin
          deb_level <= sync2;
          deb_cnt   <= 16'd0;
        end else begin
          deb_cnt <= deb_cnt + 16'd1;
        end
      end else begin
        deb_cnt <= 16'd0;
      end
    end
  end

  assign press      = deb_level & ~deb_prev;
  assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign offset_sum = scroll_offset + 4'(SCROLL_STEP);
  assign hit        = frame_start & collision;
  assign wrap       = (state == S_SCROLL) & frame_start & ~collision & (offset_sum == 4'd0);

  // Collision outranks both a press (PLAY) and a wrap (SCROLL).
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (press) state_d = S_PLAY;
      S_PLAY: begin
        if (hit)        state_d = S_DEAD;
        else if (press) state_d = S_SCROLL;
      end
      S_SCROLL: begin
        if (hit)       state_d = S_DEAD;
        else if (wrap) state_d = (pending | press) ? S_SCROLL : S_PLAY;
      end
      S_DEAD: if (frame_start && dead_cnt == 16'(DEAD_FRAMES - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      game_over     <= 1'b0;
      scroll_offset <= 4'd0;
      lane_shift    <= 1'b0;
      new_lane      <= LFSR_SEED[1:0];
      score         <= 8'd0;
      lfsr          <= LFSR_SEED;
      pending       <= 1'b0;
      dead_cnt      <= 16'd0;
    end else begin
      state      <= state_d;
      game_over  <= (state_d == S_DEAD);
      lane_shift <= wrap;

      if (state == S_IDLE && press) begin
        score         <= 8'd0;
        scroll_offset <= 4'd0;
      end else if (state == S_SCROLL && frame_start && !collision) begin
        scroll_offset <= offset_sum;
      end

      if (wrap) begin
        lfsr     <= lfsr_next;
        new_lane <= lfsr_next[1:0];
        score    <= (score == 8'hFF) ? score : score + 8'd1;
      end

      // One-deep press queue, only meaningful while scrolling.
      if (state == S_SCROLL) begin
        if (hit || wrap) pending <= 1'b0;
        else if (press)  pending <= 1'b1;
      end else begin
        pending <= 1'b0;
      end

      if (state != S_DEAD)      dead_cnt <= 16'd0;
      else if (frame_start)     dead_cnt <= (state_d == S_IDLE) ? 16'd0 : dead_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_crossyroad_game_ctrl.sv
// Bench for crossyroad_game_ctrl: frame vector table, lane-advance
// scoreboard, and hand-written debounce/collision/death/reset sequences.
module tb_crossyroad_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_btn = 1'b0;
  logic       frame_start = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic [3:0] scroll_offset;
  logic       lane_shift;
  logic [1:0] new_lane;
  logic [7:0] score;
  logic       game_over;

  int n_pass = 0;
  int n_total = 0;

  logic [9:0] exp_q[$];
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_score = 8'd0;

  typedef struct {
    logic       col;
    logic [3:0] off;
    logic       ls;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[8];

  crossyroad_game_ctrl #(
    .DEB_CYCLES (16'd4),
    .SCROLL_STEP(2),
    .DEAD_FRAMES(3),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move_btn     (move_btn),
    .frame_start  (frame_start),
    .collision    (collision),
    .state        (state),
    .scroll_offset(scroll_offset),
    .lane_shift   (lane_shift),
    .new_lane     (new_lane),
    .score        (score),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    move_btn = 1'b1;
    repeat (8) tick();
    move_btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic frame(input logic col);
    frame_start = 1'b1;
    collision   = col;
    tick();
    frame_start = 1'b0;
    collision   = 1'b0;
  endtask

  // Model of one lane advance: next LFSR (taps 8,6,5,4) and saturating score.
  task automatic push_adv();
    m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_score = (m_score == 8'hFF) ? 8'hFF : m_score + 8'd1;
    exp_q.push_back({m_score, m_lfsr[1:0]});
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].col);
      check("tbl_offset", 32'(scroll_offset), 32'(tbl[i].off));
      check("tbl_lane_shift", 32'(lane_shift), 32'(tbl[i].ls));
      if (i < 7) check("tbl_state", 32'(state), 32'(tbl[i].st));
      tick();
    end
  endtask

  // Scoreboard: every lane_shift pulse must match the oldest expected advance.
  always @(negedge clk) begin
    if (rst_n && lane_shift) begin
      if (exp_q.size() == 0) begin
        check("unexpected_lane_shift", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("sb_score", 32'(score), 32'(e[9:2]));
        check("sb_new_lane", 32'(new_lane), 32'(e[1:0]));
      end
    end
  end

  initial begin
    int got;
    for (int i = 0; i < 8; i++) begin
      tbl[i].col = 1'b0;
      tbl[i].off = 4'((2 * (i + 1)) % 16);
      tbl[i].ls  = (i == 7);
      tbl[i].st  = 2'd2;
    end

    // Reset values
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_offset", 32'(scroll_offset), 32'd0);
    check("rst_lane_shift", 32'(lane_shift), 32'd0);
    check("rst_new_lane", 32'(new_lane), 32'd1);
    check("rst_score", 32'(score), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("release_state", 32'(state), 32'd0);

    // 3-cycle glitch must not register a press
    move_btn = 1'b1;
    repeat (3) tick();
    move_btn = 1'b0;
    repeat (10) tick();
    check("glitch_state", 32'(state), 32'd0);

    // 4-cycle hold: PLAY within 6-7 cycles of the rising edge
    got = 0;
    move_btn = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 4) move_btn = 1'b0;
      if (state == 2'd1 && got == 0) got = n;
    end
    check("hold_latency_ok", 32'(got >= 6 && got <= 7), 32'd1);
    check("hold_state", 32'(state), 32'd1);
    repeat (8) tick();

    // Single lane advance
    press();
    check("scroll_entry", 32'(state), 32'd2);
    push_adv();
    run_table();
    check("scroll_end_state", 32'(state), 32'd1);
    check("scroll_score", 32'(score), 32'd1);

    // Queued press: two advances, third press dropped
    press();
    press();
    press();
    push_adv();
    push_adv();
    run_table();
    check("queue_restart_state", 32'(state), 32'd2);
    run_table();
    check("queue_end_state", 32'(state), 32'd1);
    check("queue_score", 32'(score), 32'(m_score));
    repeat (8) frame(1'b0);
    check("queue_no_third", 32'(score), 32'(m_score));
    check("queue_offset", 32'(scroll_offset), 32'd0);

    // Collision on the frame that would wrap
    press();
    repeat (7) begin
      frame(1'b0);
      tick();
    end
    check("col_pre_offset", 32'(scroll_offset), 32'd14);
    frame(1'b1);
    check("col_state", 32'(state), 32'd3);
    check("col_game_over", 32'(game_over), 32'd1);
    check("col_lane_shift", 32'(lane_shift), 32'd0);
    check("col_score", 32'(score), 32'(m_score));
    check("col_offset", 32'(scroll_offset), 32'd14);

    // Death timeout with an ignored press
    press();
    check("dead_press_ignored", 32'(state), 32'd3);
    frame(1'b0);
    tick();
    frame(1'b0);
    tick();
    check("dead_hold_state", 32'(state), 32'd3);
    check("dead_hold_offset", 32'(scroll_offset), 32'd14);
    frame(1'b0);
    check("dead_exit_state", 32'(state), 32'd0);
    check("dead_exit_game_over", 32'(game_over), 32'd0);
    repeat (4) tick();
    check("idle_after_dead", 32'(state), 32'd0);
    press();
    m_score = 8'd0;
    check("new_game_state", 32'(state), 32'd1);
    check("new_game_score", 32'(score), 32'd0);
    check("new_game_offset", 32'(scroll_offset), 32'd0);

    // Saturation: 256 advances
    for (int k = 0; k < 256; k++) begin
      press();
      push_adv();
      run_table();
    end
    check("sat_score", 32'(score), 32'd255);
    check("sat_state", 32'(state), 32'd1);

    // Asynchronous reset mid-scroll
    press();
    repeat (3) begin
      frame(1'b0);
      tick();
    end
    check("pre_rst_state", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_offset", 32'(scroll_offset), 32'd0);
    check("arst_lane_shift", 32'(lane_shift), 32'd0);
    check("arst_new_lane", 32'(new_lane), 32'd1);
    check("arst_score", 32'(score), 32'd0);
    check("arst_game_over", 32'(game_over), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    m_lfsr  = 8'hA5;
    m_score = 8'd0;
    repeat (10) tick();
    check("post_rst_state", 32'(state), 32'd0);
    frame(1'b0);
    check("post_rst_idle_frame", 32'(scroll_offset), 32'd0);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
